switch_debounce4: RTL



---
 rtl/switch_debounce4.sv | 115 +++++++++++
 1 files changed

// File: rtl/switch_debounce4.sv
// rtl/switch_debounce4.sv - four-channel switch synchroniser and debouncer feeding the AOI gate inputs.
// Optional edge pulses on rise_pulse/fall_pulse are enabled by defining SWITCH_DEBOUNCE_EDGE_EN.
module switch_debounce4 #(
    parameter int                 WIDTH      = 4,
    parameter int                 DEB_CYCLES = 1000000,
    parameter int                 CNT_W      = 24,
    parameter logic [WIDTH-1:0]   RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] busy,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Plain two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             stable_q;
        logic             busy_q;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        logic             rise_q;
        logic             fall_q;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_STABLE;
                cnt      <= '0;
                stable_q <= RST_VAL[i];
                busy_q   <= 1'b0;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
`endif
            end else begin
`ifdef SWITCH_DEBOUNCE_EDGE_EN
                rise_q <= 1'b0;
                fall_q <= 1'b0;
`endif
                case (state)
                    ST_STABLE: begin
                        if (sync2[i] != stable_q) begin
                            state  <= ST_COUNT;
                            cnt    <= CNT_ONE;
                            busy_q <= 1'b1;
                        end else begin
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end
                    end
                    ST_COUNT: begin
                        // Any bounce throws away all accumulated qualification time.
                        if (sync2[i] == stable_q) begin
                            state  <= ST_STABLE;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state    <= ST_STABLE;
                            cnt      <= '0;
                            busy_q   <= 1'b0;
                            stable_q <= sync2[i];
`ifdef SWITCH_DEBOUNCE_EDGE_EN
                            rise_q   <= sync2[i];
                            fall_q   <= ~sync2[i];
`endif
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state  <= ST_STABLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign stable_out[i] = stable_q;
        assign busy[i]       = busy_q;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
`else
        assign rise_pulse[i] = 1'b0;
        assign fall_pulse[i] = 1'b0;
`endif
    end

endmodule
